// File: rtl/pipelined_adder_nbit_pkg.sv
// pipelined_adder_nbit_pkg
//   Shared defaults and helpers for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   chunk_w()              : bits of carry chain resolved per stage
//   cfg_ok()               : legal parameter combination check
//   full_add()             : one-bit full adder, returns {carry, sum}
package pipelined_adder_nbit_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    function automatic int chunk_w(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/pipelined_adder_nbit_adder_chunk.sv
// adder_chunk
//   Combinational W-bit ripple-carry adder built from one-bit full adders.
//   a_i, b_i : operand chunk
//   c_i      : carry into bit 0
//   s_o      : sum chunk
//   c_o      : carry out of bit W-1
//   cmsb_o   : carry into bit W-1 (needed for signed overflow on the top chunk)
module adder_chunk
    import pipelined_adder_nbit_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o,
    output logic         cmsb_o
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < W; i++) begin
            {c[i+1], s_o[i]} = full_add(a_i[i], b_i[i], c[i]);
        end
    end

    assign c_o    = c[W];
    assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit
//   Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES
//   registered chunks of WIDTH/STAGES bits. Valid/ready on both sides.
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid / in_ready    : operand handshake
//   a, b, cin, sub         : operands; sub=1 computes a + ~b + 1 (cin ignored)
//   out_valid / out_ready  : result handshake
//   sum, cout, ovf         : result, carry out (no-borrow when sub=1), signed overflow
module pipelined_adder_nbit
    import pipelined_adder_nbit_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder_nbit: WIDTH must be a non-zero multiple of STAGES");
    end

    // Stage registers
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            c_q;
    logic                         cmsb_q;

    // Stage inputs (what stage k sees from upstream) and stage results
    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0][WIDTH-1:0] a_d, b_d, s_in, s_d;
    logic [STAGES-1:0]            c_in, c_d, cm_d;
    logic [STAGES-1:0][CHUNK-1:0] chunk_s;
    logic [STAGES-1:0]            rdy;

    // Stage 0 is fed from the ports; b is inverted here once so later stages
    // just add whatever upper bits they carry along.
    always_comb begin
        vld_d = '0;
        a_d   = '0;
        b_d   = '0;
        s_in  = '0;
        c_in  = '0;
        vld_d[0] = in_valid;
        a_d[0]   = a;
        b_d[0]   = b ^ {WIDTH{sub}};
        c_in[0]  = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            s_in[k]  = s_q[k-1];
            c_in[k]  = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(.W(CHUNK)) u_chunk (
            .a_i    (a_d[k][k*CHUNK +: CHUNK]),
            .b_i    (b_d[k][k*CHUNK +: CHUNK]),
            .c_i    (c_in[k]),
            .s_o    (chunk_s[k]),
            .c_o    (c_d[k]),
            .cmsb_o (cm_d[k])
        );
    end

    // Bits above the chunks already resolved are always zero in s_in, so
    // OR-ing the new chunk into place is enough.
    always_comb begin
        s_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_in[k] | (WIDTH'(chunk_s[k]) << (k * CHUNK));
        end
    end

    // ready_k = !valid_k || ready_{k+1}, unrolled as a running OR from the
    // output side so in_ready is combinational from out_ready.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = r | ~vld_q[k];
            rdy[k] = r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            cmsb_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_d[k];
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    s_q[k]   <= s_d[k];
                    c_q[k]   <= c_d[k];
                end
            end
            if (rdy[STAGES-1]) cmsb_q <= cm_d[STAGES-1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = c_q[STAGES-1] ^ cmsb_q;

    // Already-consumed low operand bits, the last stage's operand copy and the
    // MSB carries of non-final chunks are carried but never read.
    logic unused_ok;
    assign unused_ok = &{1'b0, a_q, b_q, cm_d};

endmodule
